// File: rtl/verifier_beta_sequencer.sv
// Walks one beta elem across NVARS (w,z) pairs and captures the product.
// Optional final scaling by scale_in: define VERIFIER_BETA_SEQ_SCALE_EN.
`ifndef F_NBITS
`define F_NBITS 61
`endif

module verifier_beta_sequencer #(
  parameter int NVARS = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NVARS-1:0][`F_NBITS-1:0]    w_vals,
  input  logic [NVARS-1:0][`F_NBITS-1:0]    z_vals,
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
  input  logic [`F_NBITS-1:0]               scale_in,
`endif
  output logic                              ready,
  output logic                              done,
  output logic [`F_NBITS-1:0]               beta_out,
  output logic                              elem_en,
  output logic                              elem_restart,
  output logic                              elem_mul_beta,
  output logic [`F_NBITS-1:0]               elem_w_val,
  output logic [`F_NBITS-1:0]               elem_z_val,
  output logic [1:0][`F_NBITS-1:0]         elem_mul_beta_in,
  input  logic                              elem_ready,
  input  logic [`F_NBITS-1:0]               elem_beta_out
);

  localparam int FW   = `F_NBITS;
  localparam int IDXW = (NVARS > 1) ? $clog2(NVARS) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
  localparam logic [2:0] ST_SCALE_ISSUE = 3'd4;
  localparam logic [2:0] ST_SCALE_WAIT  = 3'd5;
`endif

  logic [2:0]      state;
  logic [IDXW-1:0] idx;
  logic            guard;
  logic            idx_last;
  logic            wait_ok;
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
  logic [FW-1:0]   scale_beta;
`endif

  assign idx_last = (idx == IDXW'(NVARS - 1));
  assign ready    = (state == ST_IDLE) & elem_ready;
  // First wait cycle is skipped: elem ready may still reflect the prior op
  assign wait_ok  = ~guard & elem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      guard    <= 1'b0;
      done     <= 1'b0;
      beta_out <= '0;
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
      scale_beta <= '0;
`endif
    end else begin
      done  <= 1'b0;
      guard <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && ready) begin
            idx   <= '0;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          guard <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_ok) begin
            if (idx_last) begin
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
              scale_beta <= elem_beta_out;
              state      <= ST_SCALE_ISSUE;
`else
              beta_out <= elem_beta_out;
              done     <= 1'b1;
              state    <= ST_DONE;
`endif
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_ISSUE;
            end
          end
        end
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
        ST_SCALE_ISSUE: begin
          guard <= 1'b1;
          state <= ST_SCALE_WAIT;
        end
        ST_SCALE_WAIT: begin
          if (wait_ok) begin
            beta_out <= elem_beta_out;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    elem_en          = 1'b0;
    elem_restart     = 1'b0;
    elem_mul_beta    = 1'b0;
    elem_w_val       = '0;
    elem_z_val       = '0;
    elem_mul_beta_in = '0;
    unique case (state)
      ST_ISSUE: begin
        elem_en      = 1'b1;
        elem_restart = (idx == '0);
        elem_w_val   = w_vals[idx];
        elem_z_val   = z_vals[idx];
      end
      ST_WAIT: begin
        elem_w_val = w_vals[idx];
        elem_z_val = z_vals[idx];
      end
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
      ST_SCALE_ISSUE: begin
        elem_en             = 1'b1;
        elem_mul_beta       = 1'b1;
        elem_mul_beta_in[0] = scale_beta;
        elem_mul_beta_in[1] = scale_in;
      end
      ST_SCALE_WAIT: begin
        elem_mul_beta       = 1'b1;
        elem_mul_beta_in[0] = scale_beta;
        elem_mul_beta_in[1] = scale_in;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_verifier_beta_sequencer.sv
// Directed bench for verifier_beta_sequencer with behavioural beta elems.
// Two instances: NVARS=1 (A) and NVARS=4 (B).
`ifndef F_NBITS
`define F_NBITS 61
`endif

module tb_verifier_beta_sequencer;

  localparam int F = `F_NBITS;
  localparam logic [127:0] Q = (128'd1 << F) - 128'd1;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [F-1:0] mulmod(input logic [F-1:0] a,
                                          input logic [F-1:0] b);
    logic [127:0] p;
    p = 128'(a) * 128'(b);
    return F'(p % Q);
  endfunction

  function automatic logic [F-1:0] fterm(input logic [F-1:0] w,
                                         input logic [F-1:0] z);
    logic [127:0] t;
    t = 2 * 128'(mulmod(w, z)) + 1 + 2 * Q - 128'(w) - 128'(z);
    return F'(t % Q);
  endfunction

  // ---- instance A (NVARS=1) ----
  logic             a_start = 1'b0;
  logic [0:0][F-1:0] a_w = '0;
  logic [0:0][F-1:0] a_z = '0;
  logic             a_ready, a_done, a_en, a_rs, a_mb, a_erdy;
  logic [F-1:0]     a_beta, a_ew, a_ez, a_acc;
  logic [1:0][F-1:0] a_mbin;
  logic             a_enq;
  int               a_cnt, a_pulses = 0, a_rst_cnt = 0, a_hh = 0;
  logic             a_last_mb;
  logic [F-1:0]     a_last_in0, a_last_in1;
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
  logic [F-1:0]     a_scale = 1;
  logic [F-1:0]     b_scale = 1;
`endif

  verifier_beta_sequencer #(.NVARS(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start),
    .w_vals(a_w), .z_vals(a_z),
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
    .scale_in(a_scale),
`endif
    .ready(a_ready), .done(a_done), .beta_out(a_beta),
    .elem_en(a_en), .elem_restart(a_rs), .elem_mul_beta(a_mb),
    .elem_w_val(a_ew), .elem_z_val(a_ez), .elem_mul_beta_in(a_mbin),
    .elem_ready(a_erdy), .elem_beta_out(a_acc)
  );

  always @(posedge clk) begin
    if (rst) begin
      a_erdy <= 1'b1;
      a_acc  <= '0;
      a_cnt  <= 0;
      a_enq  <= 1'b0;
    end else begin
      a_enq <= a_en;
      if (a_en && a_enq) a_hh <= a_hh + 1;
      if (a_en && !a_enq) begin
        a_pulses   <= a_pulses + 1;
        if (a_rs) a_rst_cnt <= a_rst_cnt + 1;
        a_last_mb  <= a_mb;
        a_last_in0 <= a_mbin[0];
        a_last_in1 <= a_mbin[1];
        a_erdy     <= 1'b0;
        a_cnt      <= LAT_A;
        if (a_mb)      a_acc <= mulmod(a_mbin[0], a_mbin[1]);
        else if (a_rs) a_acc <= fterm(a_ew, a_ez);
        else           a_acc <= mulmod(a_acc, fterm(a_ew, a_ez));
      end else if (!a_erdy) begin
        if (a_cnt <= 1) a_erdy <= 1'b1;
        else            a_cnt  <= a_cnt - 1;
      end
    end
  end

  // ---- instance B (NVARS=4) ----
  logic             b_start = 1'b0;
  logic [3:0][F-1:0] b_w = '0;
  logic [3:0][F-1:0] b_z = '0;
  logic             b_ready, b_done, b_en, b_rs, b_mb, b_erdy;
  logic [F-1:0]     b_beta, b_ew, b_ez, b_acc;
  logic [1:0][F-1:0] b_mbin;
  logic             b_enq;
  int               b_cnt, b_pulses = 0, b_rst_cnt = 0, b_hh = 0;

  verifier_beta_sequencer #(.NVARS(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start),
    .w_vals(b_w), .z_vals(b_z),
`ifdef VERIFIER_BETA_SEQ_SCALE_EN
    .scale_in(b_scale),
`endif
    .ready(b_ready), .done(b_done), .beta_out(b_beta),
    .elem_en(b_en), .elem_restart(b_rs), .elem_mul_beta(b_mb),
    .elem_w_val(b_ew), .elem_z_val(b_ez), .elem_mul_beta_in(b_mbin),
    .elem_ready(b_erdy), .elem_beta_out(b_acc)
  );

  always @(posedge clk) begin
    if (rst) begin
      b_erdy <= 1'b1;
      b_acc  <= '0;
      b_cnt  <= 0;
      b_enq  <= 1'b0;
    end else begin
      b_enq <= b_en;
      if (b_en && b_enq) b_hh <= b_hh + 1;
      if (b_en && !b_enq) begin
        b_pulses <= b_pulses + 1;
        if (b_rs) b_rst_cnt <= b_rst_cnt + 1;
        b_erdy   <= 1'b0;
        b_cnt    <= LAT_B;
        if (b_mb)      b_acc <= mulmod(b_mbin[0], b_mbin[1]);
        else if (b_rs) b_acc <= fterm(b_ew, b_ez);
        else           b_acc <= mulmod(b_acc, fterm(b_ew, b_ez));
      end else if (!b_erdy) begin
        if (b_cnt <= 1) b_erdy <= 1'b1;
        else            b_cnt  <= b_cnt - 1;
      end
    end
  end

  task automatic run_a(input logic [F-1:0] w, input logic [F-1:0] z,
                       output logic [F-1:0] res);
    bit got;
    @(negedge clk);
    a_w[0] = w;
    a_z[0] = z;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (a_done) got = 1'b1;
    end
    check("a_done_seen", got, 1);
    res = a_beta;
  endtask

  task automatic run_b(input logic [3:0][F-1:0] w,
                       input logic [3:0][F-1:0] z,
                       input bit poke, output logic [F-1:0] res);
    bit got;
    @(negedge clk);
    b_w = w;
    b_z = z;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      b_start = poke && (i == 2);
      if (b_done) got = 1'b1;
    end
    b_start = 1'b0;
    check("b_done_seen", got, 1);
    res = b_beta;
  endtask

  logic [F-1:0] res;
  int p0, r0, ndone;
  bit hit;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_a_ready", a_ready, 1);
    check("rst_a_done", a_done, 0);
    check("rst_a_beta", a_beta, 0);
    check("rst_a_en", a_en, 0);
    check("rst_b_en", b_en, 0);
    check("rst_b_beta", b_beta, 0);

    // 1: single coordinate, 2*2*3+1-2-3 = 8
    p0 = a_pulses;
    r0 = a_rst_cnt;
    run_a(2, 3, res);
    check("t1_beta", res, 8);
    check("t1_pulses", a_pulses - p0, 1);
    check("t1_restart", a_rst_cnt - r0, 1);
    check("t1_ready_busy", a_ready, 0);
    @(negedge clk);
    check("t1_done_1cyc", a_done, 0);
    check("t1_ready_idle", a_ready, 1);

    // 2: all ones, then all zeros
    p0 = b_pulses;
    r0 = b_rst_cnt;
    run_b({4{F'(1)}}, {4{F'(1)}}, 1'b0, res);
    check("t2_ones", res, 1);
    check("t2_pulses", b_pulses - p0, 4);
    check("t2_restart", b_rst_cnt - r0, 1);
    run_b({4{F'(0)}}, {4{F'(0)}}, 1'b0, res);
    check("t2_zeros", res, 1);

    // 3: one factor is zero
    run_b({F'(1), F'(1), F'(0), F'(1)}, {4{F'(1)}}, 1'b0, res);
    check("t3_zero", res, 0);
    check("t3_en_gap", b_hh, 0);

    // 4: nontrivial vector, then back-to-back with a busy-time start poke
    // terms 8, 3, Q-3, 14 -> product Q-1008
    run_b({F'(5), F'(0), F'(3), F'(2)}, {F'(2), F'(4), F'(1), F'(3)},
          1'b0, res);
    check("t4_mixed", res, Q - 1008);
    p0 = b_pulses;
    run_b({4{F'(1)}}, {4{F'(1)}}, 1'b1, res);
    check("t4_b2b", res, 1);
    check("t4_poke_pulses", b_pulses - p0, 4);
    check("t4_en_gap", b_hh, 0);

    // 5: reset while waiting on coordinate 2
    p0 = b_pulses;
    @(negedge clk);
    b_w = {F'(5), F'(0), F'(3), F'(2)};
    b_z = {F'(2), F'(4), F'(1), F'(3)};
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (b_pulses - p0 == 2 && !b_en) hit = 1'b1;
    end
    check("t5_reach_wait", hit, 1);
    check("t5_pre_beta", b_beta, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_en_low", b_en, 0);
    check("t5_beta_zero", b_beta, 0);
    check("t5_idle", b_ready, 1);
    p0 = b_pulses;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_done) ndone++;
    end
    check("t5_no_done", ndone, 0);
    check("t5_no_pulse", b_pulses - p0, 0);
    run_b({F'(5), F'(0), F'(3), F'(2)}, {F'(2), F'(4), F'(1), F'(3)},
          1'b0, res);
    check("t5_after", res, Q - 1008);

`ifdef VERIFIER_BETA_SEQ_SCALE_EN
    // 6: scaled single coordinate, 8*5 = 40
    a_scale = 5;
    p0 = a_pulses;
    run_a(2, 3, res);
    check("t6_beta", res, 40);
    check("t6_pulses", a_pulses - p0, 2);
    check("t6_mul_beta", a_last_mb, 1);
    check("t6_in0", a_last_in0, 8);
    check("t6_in1", a_last_in1, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
